vram_arbiter: RTL

- Schedules the single-port 2K character RAM and 2K attribute RAM of the text VDU between two requesters:
  - the display fetch pipeline, which has absolute priority and issues at most one request per 8-pixel character slot;
  - the CPU memory window at B8000-BBFFF, which is byte-addressed, with a[0] selecting attribute versus character.
- CPU writes are posted through a small FIFO.
- CPU reads are ordered behind all posted writes.
- Sits between the bus decode logic and the charram/attrram instances.

---
 rtl/vram_pkg.sv | 30 +++
 rtl/vram_wfifo.sv | 60 ++++++
 rtl/vram_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared constants, read FSM states and posted-write entry type for the VDU RAM arbiter
package vram_pkg;

    localparam int VRAM_ADDR_W = 11;
    localparam int VRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_PEND  = 2'd1,
        RD_ISSUE = 2'd2,
        RD_DONE  = 2'd3
    } rd_state_e;

    typedef struct packed {
        logic [VRAM_ADDR_W-1:0] addr;
        logic                   sel;
        logic [VRAM_DATA_W-1:0] data;
    } wentry_t;

    // Byte offset bit 0 picks the attribute plane; the rest is the shared word address.
    function automatic wentry_t make_entry(input logic [VRAM_ADDR_W:0]   byte_addr,
                                           input logic [VRAM_DATA_W-1:0] wdata);
        wentry_t e;
        e.addr = byte_addr[VRAM_ADDR_W:1];
        e.sel  = byte_addr[0];
        e.data = wdata;
        return e;
    endfunction

endpackage

// File: rtl/vram_wfifo.sv
// rtl/vram_wfifo.sv - posted CPU write FIFO; push and pop may coincide at any occupancy
module vram_wfifo
    import vram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    push_i,
    input  wentry_t push_data_i,
    input  logic    pop_i,
    output logic    full_o,
    output logic    empty_o,
    output wentry_t head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wentry_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | do_pop);
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - display/CPU scheduler for the VDU character and attribute RAMs
// Optional conflict counter enabled by defining VRAM_CONFLICT_CNT_EN.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int WFIFO_DEPTH = 4,
    parameter int ADDR_W      = VRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [7:0]        disp_char,
    output logic [7:0]        disp_attr,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W:0]   cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              buff_we,
    output logic              attr_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        buff_rdata,
    input  logic [7:0]        attr_rdata,
    output logic [15:0]       conflict_cnt
);

    rd_state_e state_q;
    rd_state_e state_d;
    logic      wr_ack_q;
    logic      disp_valid_q;
    logic      fifo_full;
    logic      fifo_empty;
    wentry_t   fifo_head;
    logic      wr_accept;
    logic      drain;
    logic      rd_ready;
    logic      rd_issue;

    assign wr_accept = ~rst & cpu_req & cpu_we & ~fifo_full & ~cpu_ack;
    assign drain     = ~rst & ~disp_req & ~fifo_empty;
    // Reads wait for every older posted write so read-after-write sees new data.
    assign rd_ready  = (state_q == RD_PEND) & fifo_empty;
    assign rd_issue  = ~rst & rd_ready & ~disp_req;

    vram_wfifo #(
        .DEPTH(WFIFO_DEPTH)
    ) u_wfifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (wr_accept),
        .push_data_i (make_entry(cpu_addr, cpu_wdata)),
        .pop_i       (drain),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ack_q     <= 1'b0;
            disp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ack_q     <= wr_accept;
            disp_valid_q <= disp_req;
        end
    end

    always_comb begin
        state_d   = state_q;
        ram_addr  = '0;
        buff_we   = 1'b0;
        attr_we   = 1'b0;
        ram_wdata = '0;

        if (!rst) begin
            if (disp_req) begin
                ram_addr = disp_addr;
            end else if (drain) begin
                ram_addr  = fifo_head.addr;
                ram_wdata = fifo_head.data;
                attr_we   = fifo_head.sel;
                buff_we   = ~fifo_head.sel;
            end else if (rd_issue) begin
                ram_addr = cpu_addr[ADDR_W:1];
            end
        end

        case (state_q)
            IDLE:     if (cpu_req && !cpu_we && !cpu_ack) state_d = RD_PEND;
            RD_PEND:  if (rd_issue) state_d = RD_ISSUE;
            RD_ISSUE: state_d = RD_DONE;
            RD_DONE:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // RAM data for an issued read or fetch is presented the cycle after issue.
    assign cpu_ack    = ~rst & (wr_ack_q | (state_q == RD_ISSUE));
    assign cpu_rdata  = (~rst && state_q == RD_ISSUE) ? (cpu_addr[0] ? attr_rdata : buff_rdata) : 8'h00;
    assign disp_valid = ~rst & disp_valid_q;
    assign disp_char  = disp_valid ? buff_rdata : 8'h00;
    assign disp_attr  = disp_valid ? attr_rdata : 8'h00;

`ifdef VRAM_CONFLICT_CNT_EN
    logic [15:0] conflict_q;
    logic        conflict_hit;

    assign conflict_hit = disp_req & (~fifo_empty | rd_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= 16'h0000;
        end else if (conflict_hit && conflict_q != 16'hFFFF) begin
            conflict_q <= conflict_q + 16'h0001;
        end
    end

    assign conflict_cnt = conflict_q;
`else
    assign conflict_cnt = 16'h0000;
`endif

endmodule
